// File: rtl/bcd_sec_counter.sv
// bcd_sec_counter: two-digit BCD up/down counter (default range 00..59).
// Registered BCD count q plus a one-cycle wrap flag on boundary crossings.
// A synchronous load takes priority over counting; out-of-range or non-BCD
// presets are clamped to the terminal value.
// Optional build macro BCD_SEC_COUNTER_SATURATE_EN: instead of wrapping, the
// count sticks at the boundary and wrap is raised on every enabled edge there.
module bcd_sec_counter #(
  parameter logic [3:0] MAX_TENS = 4'd5,
  parameter logic [3:0] MAX_ONES = 4'd9
) (
  input  logic       clk_tmp,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       wrap
);

  localparam logic [7:0] MAX_VAL = {MAX_TENS, MAX_ONES};

  logic [7:0] q_next;
  logic       wrap_next;
  logic       load_ok;

  // Preset is accepted only if both nibbles are decimal digits and the value
  // does not exceed the terminal count; a plain byte compare is valid here
  // because both operands are then well-formed BCD.
  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                   (load_val <= MAX_VAL);

  // Next-count logic: load > count > hold, per-nibble BCD arithmetic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = load_ok ? load_val : MAX_VAL;
    end else if (en) begin
      if (up) begin
        if (q == MAX_VAL) begin
`ifdef BCD_SEC_COUNTER_SATURATE_EN
          q_next    = MAX_VAL;
`else
          q_next    = 8'h00;
`endif
          wrap_next = 1'b1;
        end else if (q[3:0] != 4'd9) begin
          q_next = {q[7:4], q[3:0] + 4'd1};
        end else begin
          q_next = {q[7:4] + 4'd1, 4'd0};
        end
      end else begin
        if (q == 8'h00) begin
`ifdef BCD_SEC_COUNTER_SATURATE_EN
          q_next    = 8'h00;
`else
          q_next    = MAX_VAL;
`endif
          wrap_next = 1'b1;
        end else if (q[3:0] != 4'd0) begin
          q_next = {q[7:4], q[3:0] - 4'd1};
        end else begin
          q_next = {q[7:4] - 4'd1, 4'd9};
        end
      end
    end
  end

  // Count and wrap registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk_tmp or negedge rst_n) begin
    if (!rst_n) begin
      q    <= 8'h00;
      wrap <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_bcd_sec_counter.sv
// Self-checking bench for bcd_sec_counter (default 00..59 range).
// Vectors come from a table; expected results are queued when a vector is
// driven and popped after the following clk_tmp rising edge.
module tb_bcd_sec_counter;

  logic       clk_tmp = 1'b0;
  logic       rst_n;
  logic       en, up, load;
  logic [7:0] load_val;
  logic [7:0] q;
  logic       wrap;

  bcd_sec_counter #(.MAX_TENS(4'd5), .MAX_ONES(4'd9)) dut (
    .clk_tmp (clk_tmp),
    .rst_n   (rst_n),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .wrap    (wrap)
  );

  always #5 clk_tmp = ~clk_tmp;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] load_val;
    logic [7:0] exp_q;
    logic       exp_wrap;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       wrap;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [7:0] aq, input logic aw,
                       input logic [7:0] eq, input logic ew);
    n_vec++;
    if (aq !== eq || aw !== ew) begin
      n_err++;
      $display("FAIL %s: got q=%h wrap=%b, expected q=%h wrap=%b", nm, aq, aw, eq, ew);
    end
  endtask

  function automatic void add(input logic ld, input logic e, input logic u,
                              input logic [7:0] lv, input logic [7:0] eq,
                              input logic ew, input string nm);
    vec_t v;
    v.load = ld; v.en = e; v.up = u; v.load_val = lv;
    v.exp_q = eq; v.exp_wrap = ew; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Drive one vector between edges, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk_tmp);
    load = v.load; en = v.en; up = v.up; load_val = v.load_val;
    e.q = v.exp_q; e.wrap = v.exp_wrap; e.name = v.name;
    sb.push_back(e);
    @(posedge clk_tmp);
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_empty: got no entry, expected one for %s", v.name);
    end else begin
      e = sb.pop_front();
      check(e.name, q, wrap, e.q, e.wrap);
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 8'h00;
    #12;
    check("reset_state", q, wrap, 8'h00, 1'b0);
    @(negedge clk_tmp);
    rst_n = 1'b1;

    // Reset mid-count: reach 37, then drop rst_n between edges.
    add(1, 1, 1, 8'h36, 8'h36, 0, "load_36");
    add(0, 1, 1, 8'h00, 8'h37, 0, "up_to_37");
    run_table();
    #2;
    load = 1'b0; en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid", q, wrap, 8'h00, 1'b0);
    @(negedge clk_tmp);
    rst_n = 1'b1;
    add(0, 1, 1, 8'h00, 8'h01, 0, "post_reset_1");
    add(0, 1, 1, 8'h00, 8'h02, 0, "post_reset_2");
    add(0, 1, 1, 8'h00, 8'h03, 0, "post_reset_3");

    // Ones rollover and borrow.
    add(1, 0, 1, 8'h19, 8'h19, 0, "load_19");
    add(0, 1, 1, 8'h00, 8'h20, 0, "ones_carry");
    add(1, 0, 0, 8'h30, 8'h30, 0, "load_30");
    add(0, 1, 0, 8'h00, 8'h29, 0, "ones_borrow");

    // Load priority over en and clamping.
    add(1, 1, 1, 8'h42, 8'h42, 0, "load_pri_42");
    add(1, 1, 1, 8'h7A, 8'h59, 0, "clamp_7A");
    add(1, 1, 0, 8'h3C, 8'h59, 0, "clamp_3C");
    add(1, 0, 0, 8'h60, 8'h59, 0, "clamp_60");
    add(1, 0, 0, 8'h00, 8'h00, 0, "load_00");

    // Hold then direction switching.
    add(1, 0, 0, 8'h10, 8'h10, 0, "load_10");
    add(0, 0, 1, 8'h00, 8'h10, 0, "hold_1");
    add(0, 0, 0, 8'h00, 8'h10, 0, "hold_2");
    add(0, 0, 1, 8'h00, 8'h10, 0, "hold_3");
    add(0, 1, 1, 8'h00, 8'h11, 0, "dir_up");
    add(0, 1, 0, 8'h00, 8'h10, 0, "dir_down");
    add(0, 1, 1, 8'h00, 8'h11, 0, "dir_up_again");

`ifndef BCD_SEC_COUNTER_SATURATE_EN
    // Up wrap.
    add(1, 0, 1, 8'h58, 8'h58, 0, "load_58");
    add(0, 1, 1, 8'h00, 8'h59, 0, "up_59");
    add(0, 1, 1, 8'h00, 8'h00, 1, "up_wrap_00");
    add(0, 1, 1, 8'h00, 8'h01, 0, "up_after_wrap");
    // Down wrap.
    add(1, 0, 0, 8'h01, 8'h01, 0, "load_01");
    add(0, 1, 0, 8'h00, 8'h00, 0, "down_00");
    add(0, 1, 0, 8'h00, 8'h59, 1, "down_wrap_59");
    add(0, 1, 0, 8'h00, 8'h58, 0, "down_after_wrap");
    // Wrap cleared by hold and by load.
    add(1, 0, 1, 8'h59, 8'h59, 0, "load_59");
    add(0, 1, 1, 8'h00, 8'h00, 1, "wrap_again");
    add(0, 0, 1, 8'h00, 8'h00, 0, "hold_clears_wrap");
    add(0, 1, 0, 8'h00, 8'h59, 1, "down_wrap_from_hold");
    add(1, 1, 0, 8'h05, 8'h05, 0, "load_clears_wrap");
`else
    // Saturate at MAX going up, leave by reversing.
    add(1, 0, 1, 8'h59, 8'h59, 0, "sat_load_59");
    add(0, 1, 1, 8'h00, 8'h59, 1, "sat_up_1");
    add(0, 1, 1, 8'h00, 8'h59, 1, "sat_up_2");
    add(0, 1, 1, 8'h00, 8'h59, 1, "sat_up_3");
    add(0, 1, 0, 8'h00, 8'h58, 0, "sat_leave_down");
    // Saturate at 00 going down, leave by reversing.
    add(1, 0, 0, 8'h01, 8'h01, 0, "sat_load_01");
    add(0, 1, 0, 8'h00, 8'h00, 0, "sat_down_00");
    add(0, 1, 0, 8'h00, 8'h00, 1, "sat_down_1");
    add(0, 1, 0, 8'h00, 8'h00, 1, "sat_down_2");
    add(0, 1, 1, 8'h00, 8'h01, 0, "sat_leave_up");
    // Leave the boundary by load.
    add(1, 0, 1, 8'h59, 8'h59, 0, "sat_load_59b");
    add(0, 1, 1, 8'h00, 8'h59, 1, "sat_up_4");
    add(1, 1, 1, 8'h05, 8'h05, 0, "sat_load_clears");
`endif
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
